// File: rtl/piso_stream_serializer.sv
// Parallel-in/serial-out serializer with a one-word holding register so that
// consecutive words leave the shifter with no idle bit between them.
module piso_stream_serializer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter bit          MSB_FIRST  = 1'b1,
  parameter bit          IDLE_LEVEL = 1'b1,
  parameter int unsigned CNT_W      = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_ready,
  input  logic                  shift_en,
  output logic                  ser_out,
  output logic                  ser_frame,
  output logic                  busy
);

  typedef enum logic {S_IDLE, S_SHIFT} state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic                  hold_full_q, hold_full_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  ser_out_q, ser_out_d;
  logic                  ser_frame_q, ser_frame_d;
  logic                  load;

  assign s_ready   = !hold_full_q && !rst;
  assign ser_out   = ser_out_q;
  assign ser_frame = ser_frame_q;
  assign busy      = (state_q == S_SHIFT);

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shreg_d     = shreg_q;
    cnt_d       = cnt_q;
    ser_out_d   = ser_out_q;
    ser_frame_d = ser_frame_q;
    load        = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (shift_en && hold_full_q) load = 1'b1;
      end
      S_SHIFT: begin
        if (shift_en) begin
          if (cnt_q != '0) begin
            ser_frame_d = 1'b0;
            cnt_d       = cnt_q - 1'b1;
            if (MSB_FIRST) begin
              ser_out_d = shreg_q[DATA_WIDTH-1];
              shreg_d   = shreg_q << 1;
            end else begin
              ser_out_d = shreg_q[0];
              shreg_d   = shreg_q >> 1;
            end
          end else if (hold_full_q) begin
            load = 1'b1;
          end else begin
            ser_out_d   = IDLE_LEVEL;
            ser_frame_d = 1'b0;
            state_d     = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Shared by the idle start and the gapless hand-over at the last bit.
    if (load) begin
      hold_full_d = 1'b0;
      ser_frame_d = 1'b1;
      cnt_d       = CNT_W'(DATA_WIDTH - 1);
      state_d     = S_SHIFT;
      if (MSB_FIRST) begin
        ser_out_d = hold_q[DATA_WIDTH-1];
        shreg_d   = hold_q << 1;
      end else begin
        ser_out_d = hold_q[0];
        shreg_d   = hold_q >> 1;
      end
    end

    // Accept needs an empty hold, so it never coincides with a load.
    if (s_valid && s_ready) begin
      hold_d      = s_data;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shreg_q     <= '0;
      cnt_q       <= '0;
      ser_out_q   <= IDLE_LEVEL;
      ser_frame_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      ser_out_q   <= ser_out_d;
      ser_frame_q <= ser_frame_d;
    end
  end

endmodule

// File: tb/tb_piso_stream_serializer.sv
// Bench for piso_stream_serializer: an MSB-first/idle-high and an LSB-first/idle-low
// instance share one stimulus; accepted words are expanded into per-instance bit queues.
module tb_piso_stream_serializer;

  localparam int W = 8;

  logic         clk, rst, s_valid, shift_en;
  logic [W-1:0] s_data;
  logic         s_ready_a, ser_out_a, ser_frame_a, busy_a;
  logic         s_ready_b, ser_out_b, ser_frame_b, busy_b;

  piso_stream_serializer #(.DATA_WIDTH(W), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) dut_a (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready_a),
    .shift_en(shift_en), .ser_out(ser_out_a), .ser_frame(ser_frame_a), .busy(busy_a));

  piso_stream_serializer #(.DATA_WIDTH(W), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut_b (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready_b),
    .shift_en(shift_en), .ser_out(ser_out_b), .ser_frame(ser_frame_b), .busy(busy_b));

  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned period = 0;
  int unsigned se_cnt = 0;
  int unsigned gap_cnt = 0;
  int unsigned popped_a = 0;
  logic [1:0]  qa[$];
  logic [1:0]  qb[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // shift_en strobe: 0 = off, 1 = held high, N = one pulse every N cycles
  initial begin
    shift_en = 1'b0;
    forever begin
      @(negedge clk);
      if (period == 0) shift_en = 1'b0;
      else begin
        se_cnt++;
        shift_en = ((se_cnt % period) == 0);
      end
    end
  end

  // Monitor: after every shift edge pop one {frame,bit} per busy instance
  initial begin
    logic       ls, lr, so, fr, bz, idle;
    logic [1:0] e;
    logic       prev [2];
    prev[0] = 1'b1;
    prev[1] = 1'b0;
    forever begin
      @(posedge clk);
      ls = shift_en;
      lr = rst;
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        so   = (k == 0) ? ser_out_a   : ser_out_b;
        fr   = (k == 0) ? ser_frame_a : ser_frame_b;
        bz   = (k == 0) ? busy_a      : busy_b;
        idle = (k == 0) ? 1'b1 : 1'b0;
        if (!lr) begin
          if (ls && bz) begin
            checks++;
            if (((k == 0) ? qa.size() : qb.size()) == 0) begin
              errors++;
              $display("FAIL underflow[%0d]: busy=1 with no expected bit, ser_out=%b", k, so);
            end else begin
              e = (k == 0) ? qa.pop_front() : qb.pop_front();
              if (k == 0) popped_a++;
              if ({fr, so} !== e) begin
                errors++;
                $display("FAIL bit[%0d] @%0t: frame,bit=%b%b expected %b%b", k, $time, fr, so, e[1], e[0]);
              end
            end
          end else if (ls) begin
            checks++;
            if (so !== idle || fr !== 1'b0) begin
              errors++;
              $display("FAIL idle[%0d] @%0t: ser_out=%b frame=%b expected %b 0", k, $time, so, fr, idle);
            end
            if (((k == 0) ? qa.size() : qb.size()) != 0) gap_cnt++;
          end else begin
            checks++;
            if (so !== prev[k]) begin
              errors++;
              $display("FAIL hold[%0d] @%0t: ser_out=%b changed without shift_en, expected %b", k, $time, so, prev[k]);
            end
          end
        end
        prev[k] = so;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  task automatic push_word(input logic [W-1:0] w);
    for (int i = 0; i < W; i++) begin
      qa.push_back({(i == 0) ? 1'b1 : 1'b0, w[W-1-i]});
      qb.push_back({(i == 0) ? 1'b1 : 1'b0, w[i]});
    end
  endtask

  // Called and returning at a negedge; scramble changes s_data while stalled.
  task automatic send(input logic [W-1:0] w, input bit scramble);
    s_valid = 1'b1;
    s_data  = w;
    for (int c = 0; c < 200; c++) begin
      if (s_ready_a) begin
        push_word(s_data);
        @(posedge clk);
        @(negedge clk);
        return;
      end
      @(posedge clk);
      @(negedge clk);
      if (scramble) s_data = W'($urandom);
    end
    checks++;
    errors++;
    $display("FAIL send_timeout: s_ready=%b expected 1 within 200 cycles", s_ready_a);
  endtask

  task automatic wait_drain();
    for (int c = 0; c < 500; c++) begin
      if (qa.size() == 0 && qb.size() == 0 && !busy_a && !busy_b) return;
      @(posedge clk);
      @(negedge clk);
    end
    checks++;
    errors++;
    $display("FAIL drain_timeout: qa=%0d qb=%0d busy=%b%b expected empty/idle", qa.size(), qb.size(), busy_a, busy_b);
  endtask

  task automatic test_reset();
    rst    = 1'b1;
    period = 1;
    repeat (3) begin @(posedge clk); @(negedge clk); end
    checks++;
    if (ser_out_a !== 1'b1 || ser_out_b !== 1'b0 || busy_a !== 1'b0 || busy_b !== 1'b0
        || ser_frame_a !== 1'b0 || ser_frame_b !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: ser_out=%b%b busy=%b%b frame=%b%b expected 10 00 00",
               ser_out_a, ser_out_b, busy_a, busy_b, ser_frame_a, ser_frame_b);
    end
    checks++;
    if (s_ready_a !== 1'b0 || s_ready_b !== 1'b0) begin
      errors++;
      $display("FAIL ready_in_reset: s_ready=%b%b expected 00", s_ready_a, s_ready_b);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (s_ready_a !== 1'b1 || s_ready_b !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset: s_ready=%b%b expected 11", s_ready_a, s_ready_b);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset_mid_word();
    int unsigned start;
    period = 1;
    start  = popped_a;
    send(8'hC3, 1'b0);
    s_valid = 1'b0;
    for (int c = 0; c < 50 && popped_a < start + 3; c++) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (ser_out_a !== 1'b1 || ser_out_b !== 1'b0 || busy_a !== 1'b0 || busy_b !== 1'b0
        || ser_frame_a !== 1'b0 || ser_frame_b !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_word: ser_out=%b%b busy=%b%b frame=%b%b expected 10 00 00",
               ser_out_a, ser_out_b, busy_a, busy_b, ser_frame_a, ser_frame_b);
    end
    rst = 1'b0;
    qa.delete();
    qb.delete();
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (busy_a !== 1'b0 || s_ready_a !== 1'b1) begin
      errors++;
      $display("FAIL no_resume: busy=%b s_ready=%b expected 0 1", busy_a, s_ready_a);
    end
  endtask

  task automatic test_single(input logic [W-1:0] w);
    period = 1;
    send(w, 1'b0);
    s_valid = 1'b0;
    wait_drain();
  endtask

  task automatic test_back_to_back();
    int unsigned snap;
    period = 1;
    send(8'hFF, 1'b0);
    @(posedge clk);
    @(negedge clk);
    snap = gap_cnt;
    send(8'h00, 1'b0);
    send(8'h3C, 1'b0);
    s_valid = 1'b0;
    wait_drain();
    checks++;
    if (gap_cnt !== snap) begin
      errors++;
      $display("FAIL back_to_back_gap: idle bits inside stream=%0d expected 0", gap_cnt - snap);
    end
  endtask

  task automatic test_slow_shift();
    period = 4;
    send(8'h81, 1'b0);
    send(8'h7E, 1'b0);
    s_valid = 1'b0;
    checks++;
    if (s_ready_a !== 1'b0 || s_ready_b !== 1'b0) begin
      errors++;
      $display("FAIL slow_ready_drop: s_ready=%b%b expected 00 while hold is full", s_ready_a, s_ready_b);
    end
    wait_drain();
  endtask

  task automatic test_backpressure();
    period = 1;
    for (int i = 0; i < 5; i++) send(W'($urandom), 1'b1);
    s_valid = 1'b0;
    wait_drain();
  endtask

  initial begin
    rst     = 1'b1;
    s_valid = 1'b0;
    s_data  = '0;
    @(negedge clk);
    test_reset();
    test_single(8'hA5);
    test_single(8'h01);
    test_reset_mid_word();
    test_single(8'h5A);
    test_back_to_back();
    test_slow_shift();
    test_backpressure();
    period = 0;
    repeat (3) begin @(posedge clk); @(negedge clk); end
    checks++;
    if (qa.size() != 0 || qb.size() != 0) begin
      errors++;
      $display("FAIL leftover: qa=%0d qb=%0d expected 0 0", qa.size(), qb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
